// File: rtl/ecc_sed_encoder_pipe_if.sv
// Valid/ready bus for the SED parity encoder: input word side and codeword side.
// Ports: data_valid/data_ready/data/inj_en inbound, enc_valid/enc_ready/enc_codeword outbound.
interface ecc_sed_encoder_pipe_if #(
    parameter int DATA_WIDTH = 12
);
    logic                  data_valid;
    logic                  data_ready;
    logic [DATA_WIDTH-1:0] data;
    logic                  inj_en;
    logic                  enc_valid;
    logic                  enc_ready;
    logic [DATA_WIDTH:0]   enc_codeword;

    modport master (
        output data_valid,
        output data,
        output inj_en,
        output enc_ready,
        input  data_ready,
        input  enc_valid,
        input  enc_codeword
    );

    modport slave (
        input  data_valid,
        input  data,
        input  inj_en,
        input  enc_ready,
        output data_ready,
        output enc_valid,
        output enc_codeword
    );
endinterface

// File: rtl/ecc_sed_encoder_pipe.sv
// Pipelined single-error-detect encoder: appends one parity bit, two-entry skid buffer.
// Ports: clk, rst (sync, active-high), bus (slave side of the handshake), enc_count.
module ecc_sed_encoder_pipe #(
    parameter int DATA_WIDTH  = 12,
    parameter bit ODD_PARITY  = 1'b0,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    ecc_sed_encoder_pipe_if.slave  bus,
    output logic [COUNT_WIDTH-1:0] enc_count
);
    localparam int CW = DATA_WIDTH + 1;

    logic          or_valid_q, or_valid_d;
    logic          sr_valid_q, sr_valid_d;
    logic [CW-1:0] or_word_q,  or_word_d;
    logic [CW-1:0] sr_word_q,  sr_word_d;
    logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;

    logic          accept;
    logic          drain;
    logic          parity;
    logic [CW-1:0] new_word;

    // Only the skid slot gates acceptance, so data_ready is a pure flop output.
    assign accept = bus.data_valid & ~sr_valid_q;
    assign drain  = or_valid_q & bus.enc_ready;

    always_comb begin
        parity   = ^bus.data;
        if (ODD_PARITY) begin
            parity = ~parity;
        end
        new_word = {parity ^ bus.inj_en, bus.data};
    end

    always_comb begin
        or_valid_d = or_valid_q;
        sr_valid_d = sr_valid_q;
        or_word_d  = or_word_q;
        sr_word_d  = sr_word_q;
        if (drain && sr_valid_q) begin
            // data_ready is low here, so no accept can collide with the refill.
            or_word_d  = sr_word_q;
            sr_valid_d = 1'b0;
        end else if (accept && (!or_valid_q || drain)) begin
            or_word_d  = new_word;
            or_valid_d = 1'b1;
        end else if (accept) begin
            sr_word_d  = new_word;
            sr_valid_d = 1'b1;
        end else if (drain) begin
            or_valid_d = 1'b0;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (drain && (cnt_q != {COUNT_WIDTH{1'b1}})) begin
            cnt_d = cnt_q + COUNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            or_valid_q <= 1'b0;
            sr_valid_q <= 1'b0;
            or_word_q  <= '0;
            sr_word_q  <= '0;
            cnt_q      <= '0;
        end else begin
            or_valid_q <= or_valid_d;
            sr_valid_q <= sr_valid_d;
            or_word_q  <= or_word_d;
            sr_word_q  <= sr_word_d;
            cnt_q      <= cnt_d;
        end
    end

    assign bus.data_ready   = ~sr_valid_q;
    assign bus.enc_valid    = or_valid_q;
    assign bus.enc_codeword = or_word_q;
    assign enc_count        = cnt_q;
endmodule

// File: tb/tb_ecc_sed_encoder_pipe.sv
// Self-checking bench for ecc_sed_encoder_pipe over several parameter sets.
// Instances: 0 even/12, 1 odd/12, 2 even/12/count2, 3 even/1, 4 odd/64.
module tb_ecc_sed_encoder_pipe;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        vld [5];
    logic        inj [5];
    logic        rdy [5];
    logic [63:0] din [5];
    logic        dr  [5];
    logic        ev  [5];
    logic [64:0] cw  [5];
    logic [15:0] cnt [5];

    logic [15:0] cnt0, cnt1, cnt3, cnt4;
    logic [1:0]  cnt2;

    int n_cmp = 0;
    int n_bad = 0;

    ecc_sed_encoder_pipe_if #(.DATA_WIDTH(12)) if0 ();
    ecc_sed_encoder_pipe_if #(.DATA_WIDTH(12)) if1 ();
    ecc_sed_encoder_pipe_if #(.DATA_WIDTH(12)) if2 ();
    ecc_sed_encoder_pipe_if #(.DATA_WIDTH(1))  if3 ();
    ecc_sed_encoder_pipe_if #(.DATA_WIDTH(64)) if4 ();

    ecc_sed_encoder_pipe #(.DATA_WIDTH(12), .ODD_PARITY(1'b0), .COUNT_WIDTH(16))
        u0 (.clk(clk), .rst(rst), .bus(if0.slave), .enc_count(cnt0));
    ecc_sed_encoder_pipe #(.DATA_WIDTH(12), .ODD_PARITY(1'b1), .COUNT_WIDTH(16))
        u1 (.clk(clk), .rst(rst), .bus(if1.slave), .enc_count(cnt1));
    ecc_sed_encoder_pipe #(.DATA_WIDTH(12), .ODD_PARITY(1'b0), .COUNT_WIDTH(2))
        u2 (.clk(clk), .rst(rst), .bus(if2.slave), .enc_count(cnt2));
    ecc_sed_encoder_pipe #(.DATA_WIDTH(1), .ODD_PARITY(1'b0), .COUNT_WIDTH(16))
        u3 (.clk(clk), .rst(rst), .bus(if3.slave), .enc_count(cnt3));
    ecc_sed_encoder_pipe #(.DATA_WIDTH(64), .ODD_PARITY(1'b1), .COUNT_WIDTH(16))
        u4 (.clk(clk), .rst(rst), .bus(if4.slave), .enc_count(cnt4));

    assign if0.data_valid = vld[0];
    assign if0.data       = din[0][11:0];
    assign if0.inj_en     = inj[0];
    assign if0.enc_ready  = rdy[0];
    assign if1.data_valid = vld[1];
    assign if1.data       = din[1][11:0];
    assign if1.inj_en     = inj[1];
    assign if1.enc_ready  = rdy[1];
    assign if2.data_valid = vld[2];
    assign if2.data       = din[2][11:0];
    assign if2.inj_en     = inj[2];
    assign if2.enc_ready  = rdy[2];
    assign if3.data_valid = vld[3];
    assign if3.data       = din[3][0:0];
    assign if3.inj_en     = inj[3];
    assign if3.enc_ready  = rdy[3];
    assign if4.data_valid = vld[4];
    assign if4.data       = din[4];
    assign if4.inj_en     = inj[4];
    assign if4.enc_ready  = rdy[4];

    assign dr[0] = if0.data_ready;
    assign dr[1] = if1.data_ready;
    assign dr[2] = if2.data_ready;
    assign dr[3] = if3.data_ready;
    assign dr[4] = if4.data_ready;
    assign ev[0] = if0.enc_valid;
    assign ev[1] = if1.enc_valid;
    assign ev[2] = if2.enc_valid;
    assign ev[3] = if3.enc_valid;
    assign ev[4] = if4.enc_valid;
    assign cw[0] = 65'(if0.enc_codeword);
    assign cw[1] = 65'(if1.enc_codeword);
    assign cw[2] = 65'(if2.enc_codeword);
    assign cw[3] = 65'(if3.enc_codeword);
    assign cw[4] = 65'(if4.enc_codeword);
    assign cnt[0] = cnt0;
    assign cnt[1] = cnt1;
    assign cnt[2] = 16'(cnt2);
    assign cnt[3] = cnt3;
    assign cnt[4] = cnt4;

    function automatic int dw(int k);
        case (k)
            3:       return 1;
            4:       return 64;
            default: return 12;
        endcase
    endfunction

    function automatic bit is_odd(int k);
        return (k == 1) || (k == 4);
    endfunction

    function automatic int unsigned cmax(int k);
        return (k == 2) ? 3 : 65535;
    endfunction

    function automatic logic [63:0] dmask(int k);
        logic [63:0] m;
        m = '1;
        if (dw(k) < 64) m = (64'd1 << dw(k)) - 64'd1;
        return m;
    endfunction

    // Reference codeword: parity from the count of ones, then data below it.
    function automatic logic [64:0] ref_cw(int k, logic [63:0] d, logic i);
        int          ones;
        logic        p;
        logic [64:0] r;
        ones = 0;
        for (int b = 0; b < dw(k); b++) ones += int'(d[b]);
        p = (ones % 2) == 1;
        if (is_odd(k)) p = ~p;
        r = 65'(d & dmask(k));
        r[dw(k)] = p ^ i;
        return r;
    endfunction

    task automatic idle_all();
        for (int k = 0; k < 5; k++) begin
            vld[k] = 1'b0;
            inj[k] = 1'b0;
            rdy[k] = 1'b0;
            din[k] = '0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        for (int k = 0; k < 5; k++) begin
            vld[k] = 1'b1;
            inj[k] = 1'b1;
            rdy[k] = 1'b1;
            din[k] = 64'h0123_4567_89AB_CDEF;
        end
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        idle_all();
    endtask

    task automatic test_reset();
        do_reset();
        for (int k = 0; k < 5; k++) begin
            n_cmp++;
            if (ev[k] !== 1'b0) begin
                n_bad++;
                $display("FAIL reset_valid[%0d]: got %b want 0", k, ev[k]);
            end
            n_cmp++;
            if (cw[k] !== 65'd0) begin
                n_bad++;
                $display("FAIL reset_cw[%0d]: got %h want 0", k, cw[k]);
            end
            n_cmp++;
            if (cnt[k] !== 16'd0) begin
                n_bad++;
                $display("FAIL reset_cnt[%0d]: got %0d want 0", k, cnt[k]);
            end
            n_cmp++;
            if (dr[k] !== 1'b1) begin
                n_bad++;
                $display("FAIL reset_ready[%0d]: got %b want 1", k, dr[k]);
            end
        end
    endtask

    task automatic test_even();
        logic [12:0] want [2];
        logic [11:0] dat  [2];
        do_reset();
        dat[0] = 12'hA5A; want[0] = 13'h0A5A;
        dat[1] = 12'h001; want[1] = 13'h1001;
        rdy[0] = 1'b1;
        for (int i = 0; i < 2; i++) begin
            vld[0] = 1'b1;
            din[0] = 64'(dat[i]);
            tick();
            n_cmp++;
            if (ev[0] !== 1'b1 || cw[0] !== 65'(want[i])) begin
                n_bad++;
                $display("FAIL even_cw%0d: got v=%b %h want v=1 %h",
                         i, ev[0], cw[0], want[i]);
            end
        end
        vld[0] = 1'b0;
        tick();
        n_cmp++;
        if (ev[0] !== 1'b0 || cnt[0] !== 16'd2) begin
            n_bad++;
            $display("FAIL even_end: got v=%b cnt=%0d want v=0 cnt=2",
                     ev[0], cnt[0]);
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] w;
        do_reset();
        rdy[0] = 1'b1;
        for (int i = 0; i < 8; i++) begin
            w = 64'($urandom_range(0, 4095));
            vld[0] = 1'b1;
            din[0] = w;
            tick();
            n_cmp++;
            if (ev[0] !== 1'b1 || cw[0] !== ref_cw(0, w, 1'b0)) begin
                n_bad++;
                $display("FAIL b2b_%0d: got v=%b %h want v=1 %h",
                         i, ev[0], cw[0], ref_cw(0, w, 1'b0));
            end
        end
        vld[0] = 1'b0;
        tick();
        n_cmp++;
        if (cnt[0] !== 16'd8) begin
            n_bad++;
            $display("FAIL b2b_count: got %0d want 8", cnt[0]);
        end
    endtask

    task automatic test_odd();
        logic [11:0] dat  [4];
        logic        ij   [4];
        logic [12:0] want [4];
        do_reset();
        dat[0] = 12'hA5A; ij[0] = 1'b0; want[0] = 13'h1A5A;
        dat[1] = 12'h000; ij[1] = 1'b0; want[1] = 13'h1000;
        dat[2] = 12'h000; ij[2] = 1'b1; want[2] = 13'h0000;
        dat[3] = 12'h000; ij[3] = 1'b0; want[3] = 13'h1000;
        rdy[1] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            vld[1] = 1'b1;
            din[1] = 64'(dat[i]);
            inj[1] = ij[i];
            tick();
            n_cmp++;
            if (ev[1] !== 1'b1 || cw[1] !== 65'(want[i])) begin
                n_bad++;
                $display("FAIL odd_cw%0d: got v=%b %h want v=1 %h",
                         i, ev[1], cw[1], want[i]);
            end
        end
        idle_all();
    endtask

    task automatic test_backpressure();
        logic [11:0] dat [3];
        do_reset();
        dat[0] = 12'h111;
        dat[1] = 12'h222;
        dat[2] = 12'h333;
        rdy[0] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            vld[0] = 1'b1;
            din[0] = 64'(dat[i]);
            tick();
        end
        n_cmp++;
        if (dr[0] !== 1'b0 || ev[0] !== 1'b1 || cw[0] !== 65'h1111) begin
            n_bad++;
            $display("FAIL bp_full: got rdy=%b v=%b %h want rdy=0 v=1 1111",
                     dr[0], ev[0], cw[0]);
        end
        rdy[0] = 1'b1;
        tick();
        n_cmp++;
        if (cw[0] !== 65'h1222 || dr[0] !== 1'b1) begin
            n_bad++;
            $display("FAIL bp_second: got %h rdy=%b want 1222 rdy=1",
                     cw[0], dr[0]);
        end
        tick();
        n_cmp++;
        if (cw[0] !== 65'h0333 || ev[0] !== 1'b1) begin
            n_bad++;
            $display("FAIL bp_third: got v=%b %h want v=1 0333", ev[0], cw[0]);
        end
        vld[0] = 1'b0;
        tick();
        n_cmp++;
        if (ev[0] !== 1'b0 || cnt[0] !== 16'd3) begin
            n_bad++;
            $display("FAIL bp_end: got v=%b cnt=%0d want v=0 cnt=3",
                     ev[0], cnt[0]);
        end
    endtask

    task automatic test_saturation();
        int want;
        do_reset();
        rdy[2] = 1'b1;
        for (int i = 0; i < 6; i++) begin
            vld[2] = (i < 5);
            din[2] = 64'($urandom_range(0, 4095));
            tick();
            if (i >= 1) begin
                want = (i > 3) ? 3 : i;
                n_cmp++;
                if (cnt[2] !== 16'(want)) begin
                    n_bad++;
                    $display("FAIL sat_%0d: got %0d want %0d", i, cnt[2], want);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        rdy[0] = 1'b1;
        vld[0] = 1'b1;
        din[0] = 64'hAAA;
        tick();
        din[0] = 64'h111;
        tick();
        rdy[0] = 1'b0;
        din[0] = 64'h222;
        tick();
        n_cmp++;
        if (dr[0] !== 1'b0 || cnt[0] !== 16'd1) begin
            n_bad++;
            $display("FAIL mid_pre: got rdy=%b cnt=%0d want rdy=0 cnt=1",
                     dr[0], cnt[0]);
        end
        rst = 1'b1;
        rdy[0] = 1'b1;
        tick();
        rst = 1'b0;
        vld[0] = 1'b0;
        n_cmp++;
        if (ev[0] !== 1'b0 || dr[0] !== 1'b1 || cnt[0] !== 16'd0) begin
            n_bad++;
            $display("FAIL mid_rst: got v=%b rdy=%b cnt=%0d want 0 1 0",
                     ev[0], dr[0], cnt[0]);
        end
        vld[0] = 1'b1;
        din[0] = 64'hFFF;
        tick();
        n_cmp++;
        if (ev[0] !== 1'b1 || cw[0] !== 65'h0FFF) begin
            n_bad++;
            $display("FAIL mid_new: got v=%b %h want v=1 0fff", ev[0], cw[0]);
        end
        idle_all();
    endtask

    task automatic test_random(int k, int ncyc);
        logic [64:0] q [$];
        int unsigned mcnt;
        logic [64:0] prev_cw;
        logic        prev_stall;
        logic        v, r, i, acc, drn;
        logic [63:0] d;
        do_reset();
        mcnt = 0;
        prev_stall = 1'b0;
        prev_cw = '0;
        for (int c = 0; c < ncyc; c++) begin
            n_cmp++;
            if (dr[k] !== (q.size() < 2)) begin
                n_bad++;
                $display("FAIL rnd%0d_ready c%0d: got %b want %b",
                         k, c, dr[k], q.size() < 2);
            end
            n_cmp++;
            if (ev[k] !== (q.size() > 0)) begin
                n_bad++;
                $display("FAIL rnd%0d_valid c%0d: got %b want %b",
                         k, c, ev[k], q.size() > 0);
            end
            if (q.size() > 0) begin
                n_cmp++;
                if (cw[k] !== q[0]) begin
                    n_bad++;
                    $display("FAIL rnd%0d_cw c%0d: got %h want %h",
                             k, c, cw[k], q[0]);
                end
            end
            if (prev_stall) begin
                n_cmp++;
                if (cw[k] !== prev_cw) begin
                    n_bad++;
                    $display("FAIL rnd%0d_stable c%0d: got %h want %h",
                             k, c, cw[k], prev_cw);
                end
            end
            n_cmp++;
            if (cnt[k] !== 16'(mcnt)) begin
                n_bad++;
                $display("FAIL rnd%0d_cnt c%0d: got %0d want %0d",
                         k, c, cnt[k], mcnt);
            end
            v = ($urandom_range(0, 3) != 0);
            r = ($urandom_range(0, 2) != 0);
            i = ($urandom_range(0, 7) == 0);
            d = {$urandom, $urandom} & dmask(k);
            acc = v && (q.size() < 2);
            drn = r && (q.size() > 0);
            prev_stall = (q.size() > 0) && !r;
            prev_cw = cw[k];
            vld[k] = v;
            rdy[k] = r;
            inj[k] = i;
            din[k] = d;
            tick();
            if (drn) begin
                void'(q.pop_front());
                if (mcnt < cmax(k)) mcnt++;
            end
            if (acc) q.push_back(ref_cw(k, d, i));
        end
        idle_all();
    endtask

    initial begin
        rst = 1'b1;
        idle_all();
        test_reset();
        test_even();
        test_back_to_back();
        test_odd();
        test_backpressure();
        test_saturation();
        test_reset_mid();
        test_random(0, 400);
        test_random(3, 400);
        test_random(4, 400);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
